// File: rtl/ibex_pkg.sv
// ---------------------------------------------------------------------------
// ibex_pkg
// Shared types and helpers for the LSU response unit.
//   lsu_resp_state_e : FSM states of the response unit
//   LSU_TYPE_*       : access size encoding on lsu_type_i (2'b11 behaves as word)
//   lsu_misaligned   : alignment check for an access type and address LSBs
//   lsu_be           : byte enables for an access type and address LSBs
//   lsu_wdata        : store data replicated across the bus lanes
// ---------------------------------------------------------------------------
package ibex_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2,
      ERR_RESP    = 2'd3
   } lsu_resp_state_e;

   localparam logic [1:0] LSU_TYPE_WORD = 2'b00;
   localparam logic [1:0] LSU_TYPE_HALF = 2'b01;
   localparam logic [1:0] LSU_TYPE_BYTE = 2'b10;

   // Half-words need an even address, words (and the word alias) a 4-byte aligned one.
   function automatic logic lsu_misaligned(input logic [1:0] lsu_type, input logic [1:0] addr_lo);
      logic mis;
      case (lsu_type)
         LSU_TYPE_HALF: mis = addr_lo[0];
         LSU_TYPE_BYTE: mis = 1'b0;
         default:       mis = (addr_lo != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] lsu_be(input logic [1:0] lsu_type, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (lsu_type)
         LSU_TYPE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
         LSU_TYPE_BYTE: be = 4'b0001 << addr_lo;
         default:       be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicating the LSB-aligned data means the lane picked by the BE always carries it.
   function automatic logic [31:0] lsu_wdata(input logic [1:0] lsu_type, input logic [31:0] wdata);
      logic [31:0] wd;
      case (lsu_type)
         LSU_TYPE_HALF: wd = {2{wdata[15:0]}};
         LSU_TYPE_BYTE: wd = {4{wdata[7:0]}};
         default:       wd = wdata;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/ibex_lsu_load_fmt.sv
// ---------------------------------------------------------------------------
// ibex_lsu_load_fmt
// Combinational load-data formatter: shifts the addressed bytes of the bus word
// down to bit 0 and sign- or zero-extends them to 32 bits.
//   rdata     in  32  raw bus read data
//   offset    in  2   byte offset of the access within the word
//   lsu_type  in  2   access size (word/half/byte)
//   sign_ext  in  1   1: sign-extend, 0: zero-extend
//   load_data out 32  formatted load result
// ---------------------------------------------------------------------------
module ibex_lsu_load_fmt
   import ibex_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  lsu_type,
   input  logic        sign_ext,
   output logic [31:0] load_data
);

   logic [31:0] shifted_s;

   // Align the selected bytes to bit 0, then extend according to size and signedness.
   always_comb begin
      shifted_s = rdata >> {offset, 3'b000};
      case (lsu_type)
         LSU_TYPE_HALF: begin
            if (sign_ext) begin
               load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end else begin
               load_data = {16'h0000, shifted_s[15:0]};
            end
         end
         LSU_TYPE_BYTE: begin
            if (sign_ext) begin
               load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end else begin
               load_data = {24'h000000, shifted_s[7:0]};
            end
         end
         default: load_data = shifted_s;
      endcase
   end

endmodule

// File: rtl/ibex_lsu_resp_unit.sv
// ---------------------------------------------------------------------------
// ibex_lsu_resp_unit
// Producer side of the LSU response path. Takes one load/store at a time from
// ID/EX, runs the req/gnt + rvalid bus handshake, and hands a single response
// (valid/err plus formatted load data and RF write enable) to writeback.
// A new access may be accepted in the rvalid cycle of the previous one.
//   lsu_req_*/lsu_we/type/sign_ext/addr/wdata : access from ID/EX
//   data_*                                    : data bus (req/gnt, rvalid/err/rdata)
//   lsu_resp_valid/err, rf_we_lsu, rf_wdata   : response to writeback
//   busy_o                                    : an access is in flight
// Parameters: ResetAll clears the datapath registers on reset as well;
// GntTimeout > 0 aborts an ungranted request with an error after that many cycles.
// ---------------------------------------------------------------------------
module ibex_lsu_resp_unit
   import ibex_pkg::*;
#(
   parameter bit          ResetAll   = 1'b0,
   parameter int unsigned GntTimeout = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_i,
   output logic        lsu_req_ready_o,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,
   output logic        lsu_resp_valid_o,
   output logic        lsu_resp_err_o,
   output logic        rf_we_lsu_o,
   output logic [31:0] rf_wdata_lsu_o,
   output logic        busy_o
);

   localparam int unsigned CntW = 16;

   lsu_resp_state_e state_r;
   logic [CntW-1:0] cnt_r;
   logic [31:0]     addr_r;
   logic [31:0]     wdata_r;
   logic [3:0]      be_r;
   logic [1:0]      type_r;
   logic [1:0]      offset_r;
   logic            we_r;
   logic            sign_r;

   logic            accept_s;
   logic            misaligned_s;
   logic            timeout_hit_s;
   logic            rvalid_hit_s;
   logic [31:0]     load_data_s;

   // Handshake qualifiers: ready, acceptance, alignment and grant-timeout detection.
   always_comb begin
      rvalid_hit_s    = (state_r == WAIT_RVALID) & data_rvalid_i;
      lsu_req_ready_o = (state_r == IDLE) | (state_r == ERR_RESP) | rvalid_hit_s;
      accept_s        = lsu_req_i & lsu_req_ready_o;
      misaligned_s    = lsu_misaligned(lsu_type_i, lsu_addr_i[1:0]);
      if (GntTimeout != 0) begin
         timeout_hit_s = (cnt_r == CntW'(GntTimeout - 1));
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Access FSM and grant-wait counter; a new accept overrides the current state's exit.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else if (accept_s) begin
         state_r <= misaligned_s ? ERR_RESP : WAIT_GNT;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
            WAIT_GNT: begin
               // A grant arriving in the limit cycle still wins over the timeout.
               if (data_gnt_i) begin
                  state_r <= WAIT_RVALID;
                  cnt_r   <= '0;
               end else if (timeout_hit_s) begin
                  state_r <= ERR_RESP;
                  cnt_r   <= '0;
               end else begin
                  state_r <= WAIT_GNT;
                  cnt_r   <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
               end
            end
            WAIT_RVALID: begin
               state_r <= data_rvalid_i ? IDLE : WAIT_RVALID;
               cnt_r   <= '0;
            end
            ERR_RESP: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   // Capture the accepted access; these only need clearing when ResetAll is set.
   always_ff @(posedge clk_i) begin
      if (!rst_ni && ResetAll) begin
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
         be_r     <= 4'b0000;
         type_r   <= 2'b00;
         offset_r <= 2'b00;
         we_r     <= 1'b0;
         sign_r   <= 1'b0;
      end else if (rst_ni && accept_s) begin
         addr_r   <= {lsu_addr_i[31:2], 2'b00};
         wdata_r  <= lsu_wdata(lsu_type_i, lsu_wdata_i);
         be_r     <= lsu_be(lsu_type_i, lsu_addr_i[1:0]);
         type_r   <= lsu_type_i;
         offset_r <= lsu_addr_i[1:0];
         we_r     <= lsu_we_i;
         sign_r   <= lsu_sign_ext_i;
      end
   end

   ibex_lsu_load_fmt u_load_fmt (
      .rdata     (data_rdata_i),
      .offset    (offset_r),
      .lsu_type  (type_r),
      .sign_ext  (sign_r),
      .load_data (load_data_s)
   );

   // Bus fields are zeroed outside WAIT_GNT so nothing stale is presented after reset.
   always_comb begin
      data_req_o       = (state_r == WAIT_GNT);
      data_addr_o      = data_req_o ? addr_r  : 32'h0000_0000;
      data_wdata_o     = data_req_o ? wdata_r : 32'h0000_0000;
      data_be_o        = data_req_o ? be_r    : 4'b0000;
      data_we_o        = data_req_o & we_r;
      lsu_resp_valid_o = rvalid_hit_s | (state_r == ERR_RESP);
      lsu_resp_err_o   = (state_r == ERR_RESP) | (rvalid_hit_s & data_err_i);
      rf_we_lsu_o      = lsu_resp_valid_o & ~we_r & ~lsu_resp_err_o;
      rf_wdata_lsu_o   = rf_we_lsu_o ? load_data_s : 32'h0000_0000;
      busy_o           = (state_r != IDLE);
   end

endmodule
